// File: rtl/sobel_linebuf.sv
`default_nettype none
// ============================================================================
// Module      : sobel_linebuf
// Description : Streaming Sobel edge detector. Reads an RGB444 frame once in
//               raster order from a picture BRAM, converts each pixel to a
//               4-bit luma, keeps two line buffers plus a 3x3 window, and
//               writes one thresholded edge flag per interior pixel to an
//               edge BRAM. Pixels inside a configurable margin are forced to
//               "no edge".
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_linebuf #(
    parameter int WIDTH    = 640,
    parameter int HEIGHT   = 480,
    parameter int ADDR_W   = 19,
    parameter int READ_LAT = 2,
    parameter int BORDER   = 25
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [12:0]       threshold,
    output logic              busy,
    output logic              done,
    input  logic [11:0]       pixel_data,
    output logic [ADDR_W-1:0] pic_memory_addr,
    output logic              edge_we,
    output logic [ADDR_W-1:0] edge_memory_addr,
    output logic [3:0]        is_edge
);

    localparam int c_XW = $clog2(WIDTH);
    localparam int c_YW = $clog2(HEIGHT);

    localparam logic [ADDR_W-1:0] c_LAST   = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [ADDR_W-1:0] c_W_A    = ADDR_W'(WIDTH);
    localparam logic [c_XW-1:0]   c_X_MAX  = c_XW'(WIDTH - 1);
    localparam logic [c_XW-1:0]   c_X_ONE  = c_XW'(1);
    localparam logic [c_XW-1:0]   c_X_TWO  = c_XW'(2);
    localparam logic [c_YW-1:0]   c_Y_ONE  = c_YW'(1);
    localparam logic [c_YW-1:0]   c_Y_TWO  = c_YW'(2);
    localparam logic [c_XW-1:0]   c_X_LO   = c_XW'(BORDER);
    localparam logic [c_XW-1:0]   c_X_HI   = c_XW'(WIDTH - 1 - BORDER);
    localparam logic [c_YW-1:0]   c_Y_LO   = c_YW'(BORDER);
    localparam logic [c_YW-1:0]   c_Y_HI   = c_YW'(HEIGHT - 1 - BORDER);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Control / address issue
    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic [1:0]        r_mode;
    logic [12:0]       r_thr;
    logic [ADDR_W-1:0] r_addr;
    logic [c_XW-1:0]   r_x;
    logic [c_YW-1:0]   r_y;
    logic              r_iv;

    // Coordinates travelling alongside the BRAM read latency
    logic              r_pv [READ_LAT];
    logic [c_XW-1:0]   r_px [READ_LAT];
    logic [c_YW-1:0]   r_py [READ_LAT];

    // Stage A: luma plus the two older rows of the same column
    logic              r_av;
    logic [c_XW-1:0]   r_ax;
    logic [c_YW-1:0]   r_ay;
    logic [3:0]        r_luma;
    logic [3:0]        r_top;
    logic [3:0]        r_mid;
    logic [3:0]        r_lb0 [WIDTH];
    logic [3:0]        r_lb1 [WIDTH];

    // Stage B: 3x3 window, index 0 is the leftmost column
    logic              r_bv;
    logic [c_XW-1:0]   r_bx;
    logic [c_YW-1:0]   r_by;
    logic [3:0]        r_wt [3];
    logic [3:0]        r_wm [3];
    logic [3:0]        r_wb [3];

    // Stage C: gradients for the window centre
    logic              r_cv;
    logic              r_cw;
    logic              r_cforce;
    logic signed [7:0] r_gx;
    logic signed [7:0] r_gy;
    logic [c_XW-1:0]   r_ccx;
    logic [c_YW-1:0]   r_ccy;

    // Stage D: edge BRAM write port
    logic              r_edge_we;
    logic [3:0]        r_is_edge;
    logic [ADDR_W-1:0] r_edge_addr;

    logic [3:0]        w_luma;
    logic              w_unused;
    logic              w_inflight;
    logic signed [7:0] w_gx;
    logic signed [7:0] w_gy;
    logic [c_XW-1:0]   w_bcx;
    logic [c_YW-1:0]   w_bcy;
    logic              w_force;
    logic [7:0]        w_agx;
    logic [7:0]        w_agy;
    logic [12:0]       w_sq;
    logic [12:0]       w_mag;

    function automatic logic signed [7:0] sx(input logic [3:0] v);
        return $signed({4'b0000, v});
    endfunction

    // Luma = R>>2 + G>>1 + G>>3 + B>>3; the sum never exceeds 12
    assign w_luma = {2'b00, pixel_data[11:10]} + {1'b0, pixel_data[7:5]}
                  + {3'b000, pixel_data[7]} + {3'b000, pixel_data[3]};
    assign w_unused = ^{pixel_data[9:8], pixel_data[4], pixel_data[2:0]};

    // Any pixel still travelling through the pipe keeps the frame in DRAIN
    always_comb begin
        w_inflight = r_av | r_bv | r_cv;
        for (int i = 0; i < READ_LAT; i++) begin
            w_inflight = w_inflight | r_pv[i];
        end
    end

    assign w_gx = sx(r_wt[0]) - sx(r_wt[2]) + (sx(r_wm[0]) <<< 1)
                - (sx(r_wm[2]) <<< 1) + sx(r_wb[0]) - sx(r_wb[2]);
    assign w_gy = sx(r_wt[0]) + (sx(r_wt[1]) <<< 1) + sx(r_wt[2])
                - sx(r_wb[0]) - (sx(r_wb[1]) <<< 1) - sx(r_wb[2]);

    // Window centre is one column left and one row above the newest pixel
    assign w_bcx   = r_bx - c_X_ONE;
    assign w_bcy   = r_by - c_Y_ONE;
    assign w_force = (w_bcx < c_X_LO) || (w_bcx > c_X_HI)
                  || (w_bcy < c_Y_LO) || (w_bcy > c_Y_HI);

    assign w_agx = r_gx[7] ? (8'd0 - r_gx) : r_gx;
    assign w_agy = r_gy[7] ? (8'd0 - r_gy) : r_gy;
    assign w_sq  = 13'(w_agx) * 13'(w_agx) + 13'(w_agy) * 13'(w_agy);

    // Magnitude selection by the mode latched at start
    always_comb begin
        w_mag = 13'd0;
        case (r_mode)
            2'd0:    w_mag = 13'(w_agx) + 13'(w_agy);
            2'd1:    w_mag = w_sq;
            2'd2:    w_mag = 13'(w_agx);
            default: w_mag = 13'(w_agy);
        endcase
    end

    // Frame FSM: accepts start, sweeps the read address, waits for the drain
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_mode  <= 2'd0;
            r_thr   <= 13'd0;
            r_addr  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_iv    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_mode  <= mode;
                        r_thr   <= threshold;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_addr  <= '0;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_iv    <= 1'b1;
                        r_state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (r_addr == c_LAST) begin
                        r_iv    <= 1'b0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_addr <= r_addr + ADDR_W'(1);
                        if (r_x == c_X_MAX) begin
                            r_x <= '0;
                            r_y <= r_y + c_Y_ONE;
                        end else begin
                            r_x <= r_x + c_X_ONE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!w_inflight) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Valid/coordinate pipeline and the edge write port; cleared on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < READ_LAT; i++) begin
                r_pv[i] <= 1'b0;
                r_px[i] <= '0;
                r_py[i] <= '0;
            end
            r_av        <= 1'b0;
            r_ax        <= '0;
            r_ay        <= '0;
            r_luma      <= 4'd0;
            r_bv        <= 1'b0;
            r_bx        <= '0;
            r_by        <= '0;
            r_cv        <= 1'b0;
            r_cw        <= 1'b0;
            r_cforce    <= 1'b0;
            r_gx        <= '0;
            r_gy        <= '0;
            r_ccx       <= '0;
            r_ccy       <= '0;
            r_edge_we   <= 1'b0;
            r_is_edge   <= 4'b0000;
            r_edge_addr <= '0;
        end else begin
            r_pv[0] <= r_iv;
            r_px[0] <= r_x;
            r_py[0] <= r_y;
            for (int i = 1; i < READ_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_px[i] <= r_px[i-1];
                r_py[i] <= r_py[i-1];
            end

            r_av   <= r_pv[READ_LAT-1];
            r_ax   <= r_px[READ_LAT-1];
            r_ay   <= r_py[READ_LAT-1];
            r_luma <= w_luma;

            r_bv <= r_av;
            r_bx <= r_ax;
            r_by <= r_ay;

            // Only full windows inside one row produce a centre
            r_cv     <= r_bv;
            r_cw     <= r_bv && (r_bx >= c_X_TWO) && (r_by >= c_Y_TWO);
            r_cforce <= w_force;
            r_gx     <= w_gx;
            r_gy     <= w_gy;
            r_ccx    <= w_bcx;
            r_ccy    <= w_bcy;

            r_edge_we <= r_cw;
            if (r_cw) begin
                r_is_edge   <= {3'b000, (!r_cforce && (w_mag > r_thr))};
                r_edge_addr <= ADDR_W'(r_ccy) * c_W_A + ADDR_W'(r_ccx);
            end else begin
                r_is_edge <= 4'b0000;
            end
        end
    end

    // Line buffers and window: pure storage, contents before row 2 unused
    always_ff @(posedge clk) begin
        if (r_pv[READ_LAT-1]) begin
            r_top <= r_lb0[r_px[READ_LAT-1]];
            r_mid <= r_lb1[r_px[READ_LAT-1]];
            r_lb0[r_px[READ_LAT-1]] <= r_lb1[r_px[READ_LAT-1]];
            r_lb1[r_px[READ_LAT-1]] <= w_luma;
        end
        if (r_av) begin
            r_wt[0] <= r_wt[1];
            r_wt[1] <= r_wt[2];
            r_wt[2] <= r_top;
            r_wm[0] <= r_wm[1];
            r_wm[1] <= r_wm[2];
            r_wm[2] <= r_mid;
            r_wb[0] <= r_wb[1];
            r_wb[1] <= r_wb[2];
            r_wb[2] <= r_luma;
        end
    end

    assign busy             = r_busy;
    assign done             = r_done;
    assign pic_memory_addr  = r_addr;
    assign edge_we          = r_edge_we;
    assign edge_memory_addr = r_edge_addr;
    assign is_edge          = r_is_edge;

endmodule
`default_nettype wire

// File: tb/tb_sobel_linebuf.sv
`default_nettype none
// ============================================================================
// Module      : tb_sobel_linebuf
// Description : Self-checking bench for sobel_linebuf. Two instances (margin
//               1 and margin 2) see the same images and controls; a frame
//               model computes every expected write and its cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_linebuf;

    localparam int W  = 16;
    localparam int H  = 8;
    localparam int L  = 2;
    localparam int AW = 19;

    typedef struct {
        int addr;
        int edge_v;
        int off;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [1:0]           mode;
    logic [12:0]          threshold;
    logic [1:0]           busy;
    logic [1:0]           done;
    logic [1:0]           ewe;
    logic [1:0][AW-1:0]   paddr;
    logic [1:0][AW-1:0]   eaddr;
    logic [1:0][3:0]      iedge;
    logic [1:0][11:0]     d1;
    logic [1:0][11:0]     d2;

    logic [11:0] img [W*H];
    exp_t        q0[$];
    exp_t        q1[$];
    int          cyc;
    int          n_checks;
    int          n_fail;
    int          writes [2];
    int          edges  [2];
    int          t0     [2];
    bit   [1:0]  busy_q;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Picture BRAM: two-cycle read latency per instance
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            d1[i] <= img[paddr[i][6:0]];
            d2[i] <= d1[i];
        end
    end

    sobel_linebuf #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .READ_LAT(L), .BORDER(1)) u_dut_b1 (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .threshold(threshold),
        .busy(busy[0]), .done(done[0]), .pixel_data(d2[0]), .pic_memory_addr(paddr[0]),
        .edge_we(ewe[0]), .edge_memory_addr(eaddr[0]), .is_edge(iedge[0])
    );

    sobel_linebuf #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .READ_LAT(L), .BORDER(2)) u_dut_b2 (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .threshold(threshold),
        .busy(busy[1]), .done(done[1]), .pixel_data(d2[1]), .pic_memory_addr(paddr[1]),
        .edge_we(ewe[1]), .edge_memory_addr(eaddr[1]), .is_edge(iedge[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int luma(input int p);
        int r, g, b;
        r = (p >> 8) & 15;
        g = (p >> 4) & 15;
        b = p & 15;
        return ((r >> 2) + (g >> 1) + (g >> 3) + (b >> 3)) & 15;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // 0: uniform 0x888, 1: vertical step at column 8, 2: random
    task automatic fill(input int kind);
        for (int k = 0; k < W*H; k++) begin
            case (kind)
                0:       img[k] = 12'h888;
                1:       img[k] = ((k % W) < 8) ? 12'h000 : 12'hFFF;
                default: img[k] = 12'($urandom);
            endcase
        end
    endtask

    // Expected write list for both margins, in raster order
    task automatic build(input int md, input int th, output int e1, output int e2);
        q0.delete();
        q1.delete();
        e1 = 0;
        e2 = 0;
        for (int b = 1; b <= 2; b++) begin
            for (int cy = 1; cy <= H-2; cy++) begin
                for (int cx = 1; cx <= W-2; cx++) begin
                    int   p [9];
                    int   gx, gy, mag;
                    bit   forced, ed;
                    exp_t e;
                    for (int k = 0; k < 9; k++)
                        p[k] = luma(int'(img[(cy + k/3 - 1)*W + cx + k%3 - 1]));
                    gx = p[0] - p[2] + 2*p[3] - 2*p[5] + p[6] - p[8];
                    gy = p[0] + 2*p[1] + p[2] - p[6] - 2*p[7] - p[8];
                    case (md)
                        0:       mag = iabs(gx) + iabs(gy);
                        1:       mag = gx*gx + gy*gy;
                        2:       mag = iabs(gx);
                        default: mag = iabs(gy);
                    endcase
                    mag    = mag % 8192;
                    forced = (cx < b) || (cx > W-1-b) || (cy < b) || (cy > H-1-b);
                    ed     = !forced && (mag > th);
                    e.addr   = cy*W + cx;
                    e.edge_v = int'(ed);
                    e.off    = (cy+1)*W + cx + 1 + L + 4;
                    if (b == 1) begin
                        q0.push_back(e);
                        e1 += int'(ed);
                    end else begin
                        q1.push_back(e);
                        e2 += int'(ed);
                    end
                end
            end
        end
    endtask

    // Per-cycle comparison of every edge write against the model
    initial begin
        busy_q = '0;
        for (int i = 0; i < 2; i++) begin
            t0[i] = 0;
            writes[i] = 0;
            edges[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (busy[i] === 1'b1 && !busy_q[i]) t0[i] = cyc;
                busy_q[i] = (busy[i] === 1'b1);
                if (ewe[i] === 1'b1) begin
                    exp_t e;
                    int   have;
                    writes[i]++;
                    if (iedge[i] == 4'b0001) edges[i]++;
                    have = (i == 0) ? q0.size() : q1.size();
                    if (have == 0) begin
                        chk($sformatf("unexpected_write_b%0d", i+1), int'(ewe[i]), 0);
                    end else begin
                        if (i == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        chk($sformatf("write_addr_b%0d", i+1), int'(eaddr[i]), e.addr);
                        chk($sformatf("is_edge_b%0d@%0d", i+1, e.addr), int'(iedge[i]), e.edge_v);
                        chk($sformatf("latency_b%0d@%0d", i+1, e.addr), cyc - t0[i], e.off);
                    end
                end
            end
        end
    end

    task automatic check_idle_regs(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_busy_b%0d", tag, i+1), int'(busy[i]), 0);
            chk($sformatf("%s_done_b%0d", tag, i+1), int'(done[i]), 0);
            chk($sformatf("%s_edge_we_b%0d", tag, i+1), int'(ewe[i]), 0);
            chk($sformatf("%s_is_edge_b%0d", tag, i+1), int'(iedge[i]), 0);
            chk($sformatf("%s_pic_addr_b%0d", tag, i+1), int'(paddr[i]), 0);
            chk($sformatf("%s_edge_addr_b%0d", tag, i+1), int'(eaddr[i]), 0);
        end
    endtask

    // One frame; lit1/lit2 < 0 means "no hand-computed edge count"
    task automatic run_frame(input int md, input int th, input int lit1, input int lit2,
                             input bit poke, input string tag);
        int m1, m2, c;
        build(md, th, m1, m2);
        if (lit1 >= 0) chk({tag, "_model_edges_b1"}, m1, lit1);
        if (lit2 >= 0) chk({tag, "_model_edges_b2"}, m2, lit2);
        for (int i = 0; i < 2; i++) begin
            writes[i] = 0;
            edges[i]  = 0;
        end
        start     = 1'b1;
        mode      = 2'(md);
        threshold = 13'(th);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_busy_after_start_b%0d", tag, i+1), int'(busy[i]), 1);
            chk($sformatf("%s_done_cleared_b%0d", tag, i+1), int'(done[i]), 0);
        end
        c = 0;
        while (!(done[0] === 1'b1 && done[1] === 1'b1) && c < 1000) begin
            if (poke && c == 40) begin
                start     = 1'b1;
                mode      = 2'd1;
                threshold = 13'd8000;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            c++;
        end
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_done_b%0d", tag, i+1), int'(done[i] === 1'b1), 1);
            chk($sformatf("%s_busy_end_b%0d", tag, i+1), int'(busy[i]), 0);
            chk($sformatf("%s_writes_b%0d", tag, i+1), writes[i], 84);
            chk($sformatf("%s_dut_edges_b%0d", tag, i+1), edges[i], (i == 0) ? m1 : m2);
        end
        chk({tag, "_left_b1"}, q0.size(), 0);
        chk({tag, "_left_b2"}, q1.size(), 0);
        if (lit1 >= 0) chk({tag, "_edges_lit_b1"}, edges[0], lit1);
        if (lit2 >= 0) chk({tag, "_edges_lit_b2"}, edges[1], lit2);
    endtask

    initial begin
        int wsave [2];
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        reset     = 1'b1;
        start     = 1'b0;
        mode      = 2'd0;
        threshold = 13'd0;
        fill(0);
        repeat (3) @(posedge clk);
        #1;
        check_idle_regs("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        chk("luma_fff", luma(12'hFFF), 12);
        chk("luma_888", luma(12'h888), 8);

        fill(0);
        run_frame(0, 0, 0, 0, 1'b0, "uniform");

        fill(1);
        run_frame(0, 47, 12, 8, 1'b0, "step_m0_t47");
        run_frame(1, 2304, 0, 0, 1'b0, "step_m1_t2304");
        run_frame(1, 2303, 12, 8, 1'b0, "step_m1_t2303");
        run_frame(2, 47, 12, 8, 1'b0, "step_m2_t47");
        run_frame(3, 0, 0, 0, 1'b0, "step_m3_t0");
        run_frame(0, 48, 0, 0, 1'b0, "step_m0_t48");

        for (int r = 0; r < 4; r++) begin
            int md, th;
            fill(2);
            md = r;
            th = (md == 1) ? int'($urandom_range(3000, 0)) : int'($urandom_range(40, 0));
            run_frame(md, th, -1, -1, 1'b0, $sformatf("rand%0d", r));
        end

        fill(1);
        run_frame(0, 47, 12, 8, 1'b1, "start_while_busy");

        // Abort a frame about 50 cycles in
        begin
            int m1, m2;
            build(0, 47, m1, m2);
            start     = 1'b1;
            mode      = 2'd0;
            threshold = 13'd47;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (49) @(posedge clk);
            #1;
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            q0.delete();
            q1.delete();
            check_idle_regs("abort");
            for (int i = 0; i < 2; i++) wsave[i] = writes[i];
            repeat (20) @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++)
                chk($sformatf("abort_no_writes_b%0d", i+1), writes[i], wsave[i]);
        end

        // Reset wins over a simultaneous start
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++)
            chk($sformatf("reset_over_start_busy_b%0d", i+1), int'(busy[i]), 0);

        run_frame(0, 47, 12, 8, 1'b0, "after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
